rsa_modexp_ctrl: RTL and testbench

Square-and-multiply sequencer for RSA modular exponentiation, result = base^exponent mod M. Scans the exponent MSB-first and issues square and multiply operations to the shared modular-multiply unit over a req/ack handshake. The multiply unit owns the modulus M and returns reduced products. Sits between the Avalon register front-end (start, operands, result readback) and the multiplier datapath.

---
 rtl/rsa_modexp_ctrl.sv | 151 +++++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_ctrl.sv
// Square-and-multiply sequencer for RSA modular exponentiation (base^exponent mod M).
// Optional operation counter output enabled by defining RSA_MODEXP_OPCOUNT_EN.
module rsa_modexp_ctrl #(
    parameter int unsigned OP_W  = 64,
    parameter int unsigned EXP_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   base,
    input  logic [EXP_W-1:0]  exponent,
    output logic              busy,
    output logic              done,
    output logic [OP_W-1:0]   result,
`ifdef RSA_MODEXP_OPCOUNT_EN
    output logic [15:0]       op_count,
`endif
    output logic              mul_req,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic              mul_ack,
    input  logic [OP_W-1:0]   mul_p
);

    localparam int unsigned IDX_W = $clog2(EXP_W);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SQR,
        MUL,
        FIN
    } state_t;

    state_t             state;
    logic [EXP_W-1:0]   e_sh;
    logic [IDX_W-1:0]   idx;
    logic [OP_W-1:0]    acc;
    logic [OP_W-1:0]    base_q;
    logic               accept;
    logic               ack_ok;
    logic               top_bit;
    logic               last_bit;

    assign accept   = (state == IDLE) && start && !done;
    assign ack_ok   = mul_req && mul_ack;
    assign top_bit  = e_sh[EXP_W-1];
    assign last_bit = (idx == '0);

    // Sequencer: mul_req is raised one cycle after entering SQR/MUL and dropped on ack,
    // which gives a guaranteed idle cycle between back-to-back requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            mul_req <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
            acc     <= OP_W'(1);
            base_q  <= '0;
            e_sh    <= '0;
            idx     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        base_q <= base;
                        e_sh   <= exponent;
                        acc    <= OP_W'(1);
                        idx    <= IDX_W'(EXP_W - 1);
                        busy   <= 1'b1;
                        state  <= (exponent == '0) ? FIN : SCAN;
                    end
                end
                SCAN: begin
                    if (top_bit) begin
                        state <= SQR;
                    end else begin
                        e_sh <= e_sh << 1;
                        idx  <= idx - IDX_W'(1);
                    end
                end
                SQR: begin
                    if (!mul_req) begin
                        mul_req <= 1'b1;
                        mul_a   <= acc;
                        mul_b   <= acc;
                    end else if (mul_ack) begin
                        acc     <= mul_p;
                        mul_req <= 1'b0;
                        if (top_bit) begin
                            state <= MUL;
                        end else if (last_bit) begin
                            state <= FIN;
                        end else begin
                            e_sh  <= e_sh << 1;
                            idx   <= idx - IDX_W'(1);
                            state <= SQR;
                        end
                    end
                end
                MUL: begin
                    if (!mul_req) begin
                        mul_req <= 1'b1;
                        mul_a   <= acc;
                        mul_b   <= base_q;
                    end else if (mul_ack) begin
                        acc     <= mul_p;
                        mul_req <= 1'b0;
                        if (last_bit) begin
                            state <= FIN;
                        end else begin
                            e_sh  <= e_sh << 1;
                            idx   <= idx - IDX_W'(1);
                            state <= SQR;
                        end
                    end
                end
                FIN: begin
                    result <= acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RSA_MODEXP_OPCOUNT_EN
    // Counts accepted multiplier results for the current job; held after done for readback.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_count <= '0;
        end else if (accept) begin
            op_count <= '0;
        end else if (ack_ok && ((state == SQR) || (state == MUL))) begin
            op_count <= op_count + 16'd1;
        end
    end
`else
    logic unused_ack_ok;
    assign unused_ack_ok = ack_ok;
`endif

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Directed bench for rsa_modexp_ctrl with a behavioural modular multiplier (M = 1000003).
module tb_rsa_modexp_ctrl;

    localparam int unsigned OP_W  = 64;
    localparam int unsigned EXP_W = 32;
    localparam logic [63:0] MODV  = 64'd1000003;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [OP_W-1:0]   base;
    logic [EXP_W-1:0]  exponent;
    logic              busy;
    logic              done;
    logic [OP_W-1:0]   result;
`ifdef RSA_MODEXP_OPCOUNT_EN
    logic [15:0]       op_count;
`endif
    logic              mul_req;
    logic [OP_W-1:0]   mul_a;
    logic [OP_W-1:0]   mul_b;
    logic              mul_ack = 1'b0;
    logic [OP_W-1:0]   mul_p = '0;

    int checks = 0;
    int errors = 0;

    // Multiplier model controls (written by the stimulus block only)
    int ack_delay  = 0;
    bit rand_delay = 1'b0;
    bit stray_en   = 1'b0;
    bit force_ack  = 1'b0;

    // Multiplier model observations (written by the model only)
    int          req_count   = 0;
    int          sqr_count   = 0;
    int          mulop_count = 0;
    int          stab_err    = 0;
    logic [63:0] opseq       = '0;
    bit          in_req      = 1'b0;
    int          cnt         = 0;
    int          cur_delay   = 0;
    logic [63:0] cap_a       = '0;
    logic [63:0] cap_b       = '0;

    rsa_modexp_ctrl #(.OP_W(OP_W), .EXP_W(EXP_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base     (base),
        .exponent (exponent),
        .busy     (busy),
        .done     (done),
        .result   (result),
`ifdef RSA_MODEXP_OPCOUNT_EN
        .op_count (op_count),
`endif
        .mul_req  (mul_req),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_ack  (mul_ack),
        .mul_p    (mul_p)
    );

    always #5 clk = ~clk;

    // Multiplier model: drives ack/product 2 time units after each rising edge
    always begin
        @(posedge clk);
        #2;
        mul_ack = 1'b0;
        if (force_ack) begin
            mul_ack = 1'b1;
            mul_p   = 64'd999;
        end else if (mul_req) begin
            if (!in_req) begin
                in_req    = 1'b1;
                cnt       = 0;
                cap_a     = mul_a;
                cap_b     = mul_b;
                req_count = req_count + 1;
                if (mul_a == mul_b) sqr_count = sqr_count + 1;
                else                mulop_count = mulop_count + 1;
                opseq     = {opseq[62:0], (mul_a != mul_b)};
                cur_delay = rand_delay ? int'($urandom_range(0, 20)) : ack_delay;
            end else if ((mul_a !== cap_a) || (mul_b !== cap_b)) begin
                stab_err = stab_err + 1;
            end
            if (cnt == cur_delay) begin
                mul_ack = 1'b1;
                mul_p   = (mul_a * mul_b) % MODV;
            end
            cnt = cnt + 1;
        end else begin
            in_req = 1'b0;
            if (stray_en && ($urandom_range(0, 2) == 0)) begin
                mul_ack = 1'b1;
                mul_p   = 64'($urandom);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Pulse start for one cycle and wait (bounded) for done; returns at the negedge where done=1
    task automatic run_op(input logic [63:0] b, input logic [31:0] e, output int cyc);
        @(negedge clk);
        base     = b;
        exponent = e;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", 64'(done), 64'd1);
    endtask

    int          cyc;
    int          r0, s0, m0, w;
    logic [63:0] golden;

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        base     = '0;
        exponent = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",    64'(busy),    64'd0);
        chk("rst_done",    64'(done),    64'd0);
        chk("rst_result",  result,       64'd0);
        chk("rst_mul_req", 64'(mul_req), 64'd0);
        chk("rst_mul_a",   mul_a,        64'd0);
        chk("rst_mul_b",   mul_b,        64'd0);
        reset = 1'b0;

        // 3^13: S M S M S S M
        ack_delay = 0;
        r0 = req_count; s0 = sqr_count; m0 = mulop_count;
        run_op(64'd3, 32'd13, cyc);
        chk("p13_result", result, 64'd594320);
        chk("p13_busy_at_done", 64'(busy), 64'd0);
        chk("p13_ops", 64'(req_count - r0), 64'd7);
        chk("p13_seq", 64'(opseq[6:0]), 64'b0101001);
        chk("p13_sqr", 64'(sqr_count - s0), 64'd4);
        chk("p13_mul", 64'(mulop_count - m0), 64'd3);
`ifdef RSA_MODEXP_OPCOUNT_EN
        chk("p13_op_count", 64'(op_count), 64'd7);
`endif
        // start while done is high must be ignored
        base = 64'd9; exponent = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse_len", 64'(done), 64'd0);
        chk("start_on_done_ignored", 64'(busy), 64'd0);
        chk("result_held", result, 64'd594320);

        // exponent 0
        r0 = req_count;
        run_op(64'd12345, 32'd0, cyc);
        chk("e0_result", result, 64'd1);
        chk("e0_latency_ok", 64'(cyc <= 2), 64'd1);
        chk("e0_no_req", 64'(req_count - r0), 64'd0);

        // 7^(2^31)
        golden = 64'd7;
        for (int i = 0; i < 31; i++) golden = (golden * golden) % MODV;
        s0 = sqr_count; m0 = mulop_count;
        run_op(64'd7, 32'h8000_0000, cyc);
        chk("msb_result", result, golden);
        chk("msb_sqr", 64'(sqr_count - s0), 64'd32);
        chk("msb_mul", 64'(mulop_count - m0), 64'd1);

        // random ack delay with stray acks
        rand_delay = 1'b1; stray_en = 1'b1;
        s0 = sqr_count; m0 = mulop_count;
        run_op(64'd2, 32'd10, cyc);
        rand_delay = 1'b0; stray_en = 1'b0;
        chk("rnd_result", result, 64'd1024);
        chk("rnd_sqr", 64'(sqr_count - s0), 64'd4);
        chk("rnd_mul", 64'(mulop_count - m0), 64'd2);

        // start while busy is ignored
        r0 = req_count;
        @(negedge clk);
        base = 64'd3; exponent = 32'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_high", 64'(busy), 64'd1);
        base = 64'd9; exponent = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!done && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk("busy_done_seen", 64'(done), 64'd1);
        chk("busy_result", result, 64'd594320);
        chk("busy_ops", 64'(req_count - r0), 64'd7);

        // reset during MUL with a late ack
        ack_delay = 10;
        r0 = req_count;
        @(negedge clk);
        base = 64'd3; exponent = 32'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while ((req_count - r0) < 2 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("mid_mul_reached", 64'(req_count - r0), 64'd2);
        chk("mid_mul_req", 64'(mul_req), 64'd1);
        reset = 1'b1; force_ack = 1'b1;
        @(negedge clk);
        reset = 1'b0; force_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_mul_req", 64'(mul_req), 64'd0);
        chk("mrst_result", result, 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        ack_delay = 0;
        run_op(64'd5, 32'd3, cyc);
        chk("after_rst_result", result, 64'd125);

        chk("operand_stability", 64'(stab_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
